// File: rtl/conv_enc_param.sv
// conv_enc_param: rate-1/2 convolutional encoder with an MSB-first parallel frame.
// Define FEC_TAIL_EN to append K-1 zero tail bits that flush the trellis to 0.
module conv_enc_param #(
    parameter int K = 4,
    parameter logic [K-1:0] G0 = 4'b1011,
    parameter logic [K-1:0] G1 = 4'b1111,
    parameter int N_BITS = 48,
`ifdef FEC_TAIL_EN
    localparam int TAIL = K - 1,
`else
    localparam int TAIL = 0,
`endif
    localparam int OUT_W = 2 * (N_BITS + TAIL)
) (
    input  logic             clck,
    input  logic             rst_n,
    input  logic             start,
    input  logic             data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] FEC,
    output logic             busy,
    output logic             status
);

    localparam int NP = N_BITS + TAIL;
    localparam int CW = $clog2(NP + 1);
    localparam logic [CW-1:0] LAST_D = CW'(N_BITS - 1);
    localparam logic [CW-1:0] LAST_T = CW'(NP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_TAIL,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [K-2:0]     r_sr;
    logic [CW-1:0]    r_cnt;
    logic [OUT_W-1:0] r_fec;
    logic             r_status;
    logic             r_busy;
    logic             r_in_ready;

    logic         w_bit;
    logic [K-1:0] w_r;
    logic         w_p0;
    logic         w_p1;
    logic         w_acc;
    logic         w_step;

    // Tail cycles shift zeros through the same encoder without a handshake.
    assign w_bit  = (r_state == S_TAIL) ? 1'b0 : data;
    assign w_r    = {w_bit, r_sr};
    assign w_p0   = ^(w_r & G0);
    assign w_p1   = ^(w_r & G1);
    assign w_acc  = r_in_ready & in_valid;
    assign w_step = w_acc | (r_state == S_TAIL);

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_fec      <= '0;
            r_status   <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
        end else if (start) begin
            r_state    <= S_DATA;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_fec      <= '0;
            r_status   <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
        end else begin
            if (w_step) begin
                for (int i = 0; i < NP; i++) begin
                    if (r_cnt == CW'(i)) begin
                        r_fec[OUT_W-1-2*i] <= w_p0;
                        r_fec[OUT_W-2-2*i] <= w_p1;
                    end
                end
                r_sr  <= w_r[K-1:1];
                r_cnt <= r_cnt + CW'(1);
            end
            case (r_state)
                S_DATA: begin
                    if (w_acc && r_cnt == LAST_D) begin
                        r_in_ready <= 1'b0;
                        if (TAIL > 0) begin
                            r_state <= S_TAIL;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_TAIL: begin
                    if (r_cnt == LAST_T) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: r_status <= 1'b1;
                default: ;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign FEC      = r_fec;
    assign busy     = r_busy;
    assign status   = r_status;

endmodule

// File: tb/tb_conv_enc_param.sv
// tb_conv_enc_param: directed + random frames against a convolution reference.
// Builds with or without FEC_TAIL_EN; expectations follow the same macro.
module tb_conv_enc_param;

`ifdef FEC_TAIL_EN
    localparam int T = 3;
`else
    localparam int T = 0;
`endif
    localparam int KK  = 4;
    localparam int NA  = 4;
    localparam int NB  = 48;
    localparam int OWA = 2 * (NA + T);
    localparam int OWB = 2 * (NB + T);

    logic clck = 1'b0;
    logic rst_n = 1'b0;

    logic a_start = 0, a_data = 0, a_valid = 0;
    logic a_rdy, a_busy, a_st;
    logic [OWA-1:0] a_fec;

    logic b_start = 0, b_data = 0, b_valid = 0;
    logic b_rdy, b_busy, b_st;
    logic [OWB-1:0] b_fec;

    int checks = 0;
    int errors = 0;

    always #5 clck = ~clck;

    conv_enc_param #(.K(KK), .G0(4'b1011), .G1(4'b1111), .N_BITS(NA)) u_a (
        .clck(clck), .rst_n(rst_n), .start(a_start), .data(a_data),
        .in_valid(a_valid), .in_ready(a_rdy), .FEC(a_fec),
        .busy(a_busy), .status(a_st)
    );

    conv_enc_param #(.K(KK), .G0(4'b1011), .G1(4'b1111), .N_BITS(NB)) u_b (
        .clck(clck), .rst_n(rst_n), .start(b_start), .data(b_data),
        .in_valid(b_valid), .in_ready(b_rdy), .FEC(b_fec),
        .busy(b_busy), .status(b_st)
    );

    // Output pair t is the mod-2 convolution of the input with each generator;
    // generator bit K-1-j weights the input j steps back, zeros past the payload.
    function automatic logic [127:0] enc_ref(input bit u[$], input int n);
        bit [KK-1:0] g0 = 4'b1011;
        bit [KK-1:0] g1 = 4'b1111;
        logic [127:0] res = '0;
        int tot = n + T;
        for (int t = 0; t < tot; t++) begin
            bit p0 = 0;
            bit p1 = 0;
            for (int j = 0; j < KK; j++) begin
                int idx = t - j;
                bit ut = (idx >= 0 && idx < n) ? u[idx] : 1'b0;
                p0 ^= g0[KK-1-j] & ut;
                p1 ^= g1[KK-1-j] & ut;
            end
            res[2*tot-1-2*t] = p0;
            res[2*tot-2-2*t] = p1;
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    task automatic start_a();
        a_start = 1;
        tick();
        a_start = 0;
    endtask

    task automatic feed_a(input bit u[$]);
        foreach (u[i]) begin
            a_valid = 1;
            a_data  = u[i];
            tick();
        end
        a_valid = 0;
    endtask

    task automatic wait_a();
        int w = 0;
        while (!a_st && w < 50) begin
            tick();
            w++;
        end
        chk("a_done_timeout", 128'(a_st), 128'd1);
    endtask

    initial begin
        bit imp[$] = '{1, 0, 0, 0};
        bit ones[$] = '{1, 1, 1, 1};
        bit col[$] = '{0, 1, 1, 0};
        bit q[$];
        logic [OWA-1:0] imp_lit;
        logic [OWB-1:0] prev;
        logic rdy_before;
        int cyc;
`ifdef FEC_TAIL_EN
        imp_lit = 14'b11_01_11_11_00_00_00;
`else
        imp_lit = 8'b11_01_11_11;
`endif

        tick();
        tick();
        chk("rst_fec", 128'(a_fec), 128'd0);
        chk("rst_status", 128'(a_st), 128'd0);
        chk("rst_busy", 128'(a_busy), 128'd0);
        chk("rst_ready", 128'(a_rdy), 128'd0);
        rst_n = 1;
        tick();
        chk("idle_ready", 128'(b_rdy), 128'd0);

        // Impulse with exact status timing
        start_a();
        chk("start_ready", 128'(a_rdy), 128'd1);
        chk("start_busy", 128'(a_busy), 128'd1);
        a_valid = 1;
        a_data  = 1;
        tick();
        chk("first_pair", 128'(a_fec[OWA-1:OWA-2]), 128'd3);
        feed_a('{0, 0, 0});
        repeat (T) tick();
        chk("imp_status_early", 128'(a_st), 128'd0);
        chk("imp_busy_done", 128'(a_busy), 128'd0);
        tick();
        chk("imp_status", 128'(a_st), 128'd1);
        chk("imp_literal", 128'(a_fec), 128'(imp_lit));
        chk("imp_model", 128'(a_fec), enc_ref(imp, NA));
        repeat (3) tick();
        chk("done_hold_fec", 128'(a_fec), 128'(imp_lit));
        chk("done_hold_st", 128'(a_st), 128'd1);

        // Asynchronous reset in the middle of a frame
        b_start = 1;
        tick();
        b_start = 0;
        for (int i = 0; i < 10; i++) begin
            b_valid = 1;
            b_data  = 1'($urandom);
            tick();
        end
        b_valid = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_fec", 128'(b_fec), 128'd0);
        chk("mid_rst_busy", 128'(b_busy), 128'd0);
        chk("mid_rst_ready", 128'(b_rdy), 128'd0);
        chk("mid_rst_st", 128'(b_st), 128'd0);
        tick();
        rst_n = 1;
        tick();

        // Backpressure: valid alternates, random payload
        b_start = 1;
        tick();
        b_start = 0;
        q = {};
        cyc = 0;
        while (!b_st && cyc < 400) begin
            b_valid = (cyc % 2 == 0);
            b_data  = 1'($urandom);
            rdy_before = b_rdy;
            if (b_valid && b_rdy) q.push_back(b_data);
            prev = b_fec;
            tick();
            if (rdy_before && !b_valid) begin
                chk("gap_hold_fec", 128'(b_fec), 128'(prev));
                chk("gap_hold_rdy", 128'(b_rdy), 128'd1);
            end
            cyc++;
        end
        b_valid = 0;
        chk("bp_timeout", 128'(b_st), 128'd1);
        chk("bp_count", 128'(q.size()), 128'(NB));
        chk("bp_model", 128'(b_fec), enc_ref(q, NB));

        // Restart right after a frame of ones
        start_a();
        feed_a(ones);
        start_a();
        chk("restart_fec", 128'(a_fec), 128'd0);
        chk("restart_st", 128'(a_st), 128'd0);
        chk("restart_busy", 128'(a_busy), 128'd1);
        feed_a(imp);
        wait_a();
        chk("restart_imp", 128'(a_fec), 128'(imp_lit));

        // start and valid collide: that bit is dropped
        a_start = 1;
        a_valid = 1;
        a_data  = 1;
        tick();
        a_start = 0;
        feed_a(col);
        wait_a();
        chk("collision", 128'(a_fec), enc_ref(col, NA));

        // Random continuous frames
        for (int f = 0; f < 4; f++) begin
            q = {};
            for (int i = 0; i < NA; i++) q.push_back(1'($urandom));
            start_a();
            feed_a(q);
            wait_a();
            chk("rand_frame", 128'(a_fec), enc_ref(q, NA));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
